sfifo_pkt_arbiter: RTL and testbench

Packet-atomic arbiter that shares the single slow (MB-readout) FIFO between two packet sources: the real-event result packer and the calibration-result packer. It latches one-cycle ready pulses, waits for enough free FIFO space, then streams a framed packet: PID, source/sequence header, payload. Per-source drop counters report requests lost to back-pressure. It sits on the 10 MHz processing clock between the position/gain/drift results and the slow FIFO write port.

---
 rtl/sfifo_pkt_arbiter_pkg.sv | 29 ++
 rtl/sfifo_req_latch.sv | 31 +++
 rtl/sfifo_pkt_arbiter.sv | 150 +++++++++++++++
 tb/tb_sfifo_pkt_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sfifo_pkt_arbiter_pkg.sv
// Shared types and constants for the slow-FIFO packet arbiter.
// SFIFO_ARB_CSUM_EN adds a trailing XOR checksum word to every packet.
package sfifo_pkt_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    PAY,
`ifdef SFIFO_ARB_CSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  localparam logic [1:0]  SRC_EVT = 2'b01;
  localparam logic [1:0]  SRC_CAL = 2'b10;
  localparam logic [31:0] PKT_PID = 32'h4142504d;

  // Words per packet: PID + header + payload (+ checksum).
  function automatic int pkt_len(input int payload_words);
`ifdef SFIFO_ARB_CSUM_EN
    return payload_words + 3;
`else
    return payload_words + 2;
`endif
  endfunction

endpackage

// File: rtl/sfifo_req_latch.sv
// Per-source request bookkeeping: pending flag, saturating drop counter
// and packet sequence number.
module sfifo_req_latch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        ack,
  output logic        pend,
  output logic [15:0] drop_cnt,
  output logic [15:0] seq
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      drop_cnt <= 16'd0;
      seq      <= 16'd0;
    end else begin
      // A new request in the ack cycle re-arms the flag rather than dropping.
      if (req)
        pend <= 1'b1;
      else if (ack)
        pend <= 1'b0;
      if (req && pend && !ack && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      if (ack)
        seq <= seq + 16'd1;
    end
  end

endmodule

// File: rtl/sfifo_pkt_arbiter.sv
// Packet-atomic round-robin arbiter feeding the slow readout FIFO.
// Optional checksum word enabled by defining SFIFO_ARB_CSUM_EN.
module sfifo_pkt_arbiter
  import sfifo_pkt_arbiter_pkg::*;
#(
  parameter int                PKT_DW           = 32,
  parameter int                PAYLOAD_WORDS    = 14,
  parameter int                FIFO_DEPTH_WORDS = 64,
  parameter int                CNT_W            = 7,
  parameter logic [PKT_DW-1:0] PID              = PKT_DW'(PKT_PID)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              evt_req,
  input  logic              cal_req,
  input  logic [PKT_DW-1:0] evt_data,
  input  logic [PKT_DW-1:0] cal_data,
  output logic [3:0]        word_idx,
  output logic              evt_ack,
  output logic              cal_ack,
  input  logic [CNT_W-1:0]  sfifo_wd,
  output logic              sfifo_wr,
  output logic [PKT_DW-1:0] sfifo_din,
  output logic              busy,
  output logic [15:0]       evt_drop_cnt,
  output logic [15:0]       cal_drop_cnt
);

  localparam int         PKT_LEN = pkt_len(PAYLOAD_WORDS);
  localparam logic [3:0] LAST_K  = 4'(PAYLOAD_WORDS - 1);

  state_t            state;
  logic [3:0]        k;
  logic              gnt_cal;
  logic              last_cal;
  logic              evt_pend, cal_pend;
  logic [15:0]       evt_seq, cal_seq;
  logic              space_ok, want_cal;
  logic [PKT_DW-1:0] src_data, hdr_word;
`ifdef SFIFO_ARB_CSUM_EN
  logic [PKT_DW-1:0] csum;
`endif

  sfifo_req_latch u_evt_latch (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (evt_req),
    .ack      (evt_ack),
    .pend     (evt_pend),
    .drop_cnt (evt_drop_cnt),
    .seq      (evt_seq)
  );

  sfifo_req_latch u_cal_latch (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (cal_req),
    .ack      (cal_ack),
    .pend     (cal_pend),
    .drop_cnt (cal_drop_cnt),
    .seq      (cal_seq)
  );

  assign space_ok = (int'(sfifo_wd) + PKT_LEN) <= FIFO_DEPTH_WORDS;
  // On a tie, serve whichever source was not granted last.
  assign want_cal = cal_pend && (!evt_pend || !last_cal);
  assign src_data = gnt_cal ? cal_data : evt_data;
  assign hdr_word = PKT_DW'({gnt_cal ? SRC_CAL : SRC_EVT, 14'b0,
                             gnt_cal ? cal_seq : evt_seq});
  // Look one word ahead so the registered write lands at the next cycle.
  assign word_idx = (state == PAY && k != LAST_K) ? k + 4'd1 : 4'd0;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= 4'd0;
      gnt_cal   <= 1'b0;
      last_cal  <= 1'b1;
      sfifo_wr  <= 1'b0;
      sfifo_din <= '0;
      evt_ack   <= 1'b0;
      cal_ack   <= 1'b0;
`ifdef SFIFO_ARB_CSUM_EN
      csum      <= '0;
`endif
    end else begin
      evt_ack <= 1'b0;
      cal_ack <= 1'b0;
      case (state)
        IDLE: begin
          if ((evt_pend || cal_pend) && space_ok) begin
            gnt_cal   <= want_cal;
            last_cal  <= want_cal;
            sfifo_wr  <= 1'b1;
            sfifo_din <= PID;
            state     <= HDR0;
          end
        end
        HDR0: begin
          sfifo_din <= hdr_word;
`ifdef SFIFO_ARB_CSUM_EN
          csum      <= hdr_word;
`endif
          state     <= HDR1;
        end
        HDR1: begin
          sfifo_din <= src_data;
`ifdef SFIFO_ARB_CSUM_EN
          csum      <= csum ^ src_data;
`endif
          k         <= 4'd0;
          state     <= PAY;
        end
        PAY: begin
          if (k == LAST_K) begin
`ifdef SFIFO_ARB_CSUM_EN
            sfifo_din <= csum;
            state     <= CSUM;
`else
            sfifo_wr  <= 1'b0;
            sfifo_din <= '0;
            evt_ack   <= !gnt_cal;
            cal_ack   <= gnt_cal;
            state     <= DONE;
`endif
          end else begin
            sfifo_din <= src_data;
`ifdef SFIFO_ARB_CSUM_EN
            csum      <= csum ^ src_data;
`endif
            k         <= k + 4'd1;
          end
        end
`ifdef SFIFO_ARB_CSUM_EN
        CSUM: begin
          sfifo_wr  <= 1'b0;
          sfifo_din <= '0;
          evt_ack   <= !gnt_cal;
          cal_ack   <= gnt_cal;
          state     <= DONE;
        end
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfifo_pkt_arbiter.sv
// Scoreboard bench for sfifo_pkt_arbiter: expected packets are queued when
// requests are driven and compared word by word as the FIFO is written.
module tb_sfifo_pkt_arbiter;

  localparam int DEPTH = 64;
  localparam int PW    = 14;
`ifdef SFIFO_ARB_CSUM_EN
  localparam int PLEN  = PW + 3;
`else
  localparam int PLEN  = PW + 2;
`endif
  localparam logic [31:0] PID_W = 32'h4142504d;

  logic        clk, rst_n;
  logic        evt_req, cal_req;
  logic [31:0] evt_data, cal_data;
  logic [3:0]  word_idx;
  logic        evt_ack, cal_ack;
  logic [6:0]  sfifo_wd;
  logic        sfifo_wr;
  logic [31:0] sfifo_din;
  logic        busy;
  logic [15:0] evt_drop_cnt, cal_drop_cnt;

  logic [31:0] evt_mem [16];
  logic [31:0] cal_mem [16];
  assign evt_data = evt_mem[word_idx];
  assign cal_data = cal_mem[word_idx];

  sfifo_pkt_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .evt_req      (evt_req),
    .cal_req      (cal_req),
    .evt_data     (evt_data),
    .cal_data     (cal_data),
    .word_idx     (word_idx),
    .evt_ack      (evt_ack),
    .cal_ack      (cal_ack),
    .sfifo_wd     (sfifo_wd),
    .sfifo_wr     (sfifo_wr),
    .sfifo_din    (sfifo_din),
    .busy         (busy),
    .evt_drop_cnt (evt_drop_cnt),
    .cal_drop_cnt (cal_drop_cnt)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] w;
    bit          first;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  ack_q[$];
  logic [15:0] evt_seq_m, cal_seq_m;
  int n_checks = 0, n_pass = 0;
  int n_wr = 0, n_pkts = 0;
  int pkt_start_cyc = -1, last_wr_cyc = -1, evt_ack_cyc = -1, cal_ack_cyc = -1;
  logic [31:0] last_wr_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_pkt(input bit is_cal);
    exp_t e;
    logic [31:0] h, x, w;
    h = {is_cal ? 2'b10 : 2'b01, 14'b0, is_cal ? cal_seq_m : evt_seq_m};
    e.w = PID_W; e.first = 1'b1; exp_q.push_back(e);
    e.w = h;     e.first = 1'b0; exp_q.push_back(e);
    x = h;
    for (int i = 0; i < PW; i++) begin
      w = is_cal ? cal_mem[i] : evt_mem[i];
      e.w = w; exp_q.push_back(e);
      x = x ^ w;
    end
`ifdef SFIFO_ARB_CSUM_EN
    e.w = x; exp_q.push_back(e);
`endif
    ack_q.push_back(is_cal ? 2'b10 : 2'b01);
    if (is_cal) cal_seq_m = cal_seq_m + 16'd1;
    else        evt_seq_m = evt_seq_m + 16'd1;
  endtask

  task automatic flush_model();
    exp_q.delete();
    ack_q.delete();
    evt_seq_m = 16'd0;
    cal_seq_m = 16'd0;
  endtask

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic samp(input int c);
    at(c);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [1:0] a;
    if (rst_n) begin
      if (sfifo_wr) begin
        if (exp_q.size() == 0) chk("sb_underrun", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("sb_word", sfifo_din, e.w);
          if (e.first) begin
            pkt_start_cyc = cyc;
            n_pkts++;
          end
          last_wr_cyc  = cyc;
          last_wr_data = sfifo_din;
          n_wr++;
        end
      end
      if (evt_ack) evt_ack_cyc = cyc;
      if (cal_ack) cal_ack_cyc = cyc;
      if (evt_ack || cal_ack) begin
        if (ack_q.size() == 0) chk("ack_underrun", 32'(ack_q.size()), 32'd1);
        else begin
          a = ack_q.pop_front();
          chk("ack_src", 32'({cal_ack, evt_ack}), 32'(a));
        end
      end
      if (!busy) chk("idx_idle", 32'(word_idx), 32'd0);
    end
  end

  initial begin
    int snap_wr, snap_pk;
    rst_n = 1'b0; evt_req = 1'b0; cal_req = 1'b0; sfifo_wd = 7'd0;
    for (int i = 0; i < 16; i++) begin
      evt_mem[i] = 32'hE0E0_0000 | 32'(i);
      cal_mem[i] = 32'hCA10_0000 + 32'(i * i);
    end
    flush_model();

    // Reset values
    samp(1);
    chk("rst_wr", 32'(sfifo_wr), 32'd0);
    chk("rst_din", sfifo_din, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx", 32'(word_idx), 32'd0);
    chk("rst_acks", 32'({cal_ack, evt_ack}), 32'd0);
    chk("rst_drops", {evt_drop_cnt, cal_drop_cnt}, 32'd0);
    at(3); rst_n = 1'b1;

    // Single event packet, request at cycle 10
    at(10); push_pkt(1'b0); evt_req = 1'b1;
    at(11); evt_req = 1'b0;
    samp(15);
    chk("t1_idx_k2", 32'(word_idx), 32'd2);
    samp(12 + PLEN);
    chk("t1_busy_ack", 32'(busy), 32'd1);
    chk("t1_wr_off", 32'(sfifo_wr), 32'd0);
    samp(13 + PLEN);
    chk("t1_busy_low", 32'(busy), 32'd0);
    chk("t1_first_wr", 32'(pkt_start_cyc), 32'd12);
    chk("t1_last_wr", 32'(last_wr_cyc), 32'(11 + PLEN));
    chk("t1_ack_cyc", 32'(evt_ack_cyc), 32'(12 + PLEN));
    chk("t1_nwr", 32'(n_wr), 32'(PLEN));

    // Fresh reset restores round-robin pointer; tie goes to event
    at(32); rst_n = 1'b0; flush_model();
    at(34); rst_n = 1'b1;
    at(40); push_pkt(1'b0); push_pkt(1'b1); evt_req = 1'b1; cal_req = 1'b1;
    at(41); evt_req = 1'b0; cal_req = 1'b0;
    // New event request in its own ack cycle: re-armed, not dropped
    at(42 + PLEN); push_pkt(1'b0); evt_req = 1'b1;
    at(43 + PLEN); evt_req = 1'b0;
    samp(45 + PLEN);
    chk("tie_evt_ack", 32'(evt_ack_cyc), 32'(42 + PLEN));
    chk("tie_gap", 32'(pkt_start_cyc - evt_ack_cyc), 32'd2);
    samp(47 + 2 * PLEN);
    chk("rr_gap", 32'(pkt_start_cyc - cal_ack_cyc), 32'd2);
    samp(100);
    chk("setwin_drop", 32'(evt_drop_cnt), 32'd0);
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // Back-pressure and drop counting
    snap_wr = n_wr; snap_pk = n_pkts;
    at(110); sfifo_wd = 7'(DEPTH - PLEN + 2);
    at(111); push_pkt(1'b0); evt_req = 1'b1;
    at(112); evt_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at(114 + 2 * i); evt_req = 1'b1;
      at(115 + 2 * i); evt_req = 1'b0;
    end
    at(122); sfifo_wd = 7'(DEPTH - PLEN + 1);
    samp(125);
    chk("bp_no_wr", 32'(n_wr - snap_wr), 32'd0);
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_drop3", 32'(evt_drop_cnt), 32'd3);
    at(126); sfifo_wd = 7'(DEPTH - PLEN);
    at(127); sfifo_wd = 7'd0;
    samp(128);
    chk("bp_pid_cyc", 32'(pkt_start_cyc), 32'd127);
    samp(150);
    chk("bp_one_pkt", 32'(n_pkts - snap_pk), 32'd1);
    chk("bp_nwr", 32'(n_wr - snap_wr), 32'(PLEN));
    chk("bp_drop_keep", 32'(evt_drop_cnt), 32'd3);

    // Reset in the middle of a packet, at payload word 5
    at(160); push_pkt(1'b0); evt_req = 1'b1;
    at(161); evt_req = 1'b0;
    at(169);
    chk("mid_wr_on", 32'(sfifo_wr), 32'd1);
    chk("mid_idx", 32'(word_idx), 32'd6);
    rst_n = 1'b0; flush_model();
    #1;
    chk("mid_rst_wr", 32'(sfifo_wr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_din", sfifo_din, 32'd0);
    chk("mid_rst_drop", 32'(evt_drop_cnt), 32'd0);
    at(171); rst_n = 1'b1;
    for (int i = 0; i < 16; i++) evt_mem[i] = 32'h1;
    at(175); push_pkt(1'b0); evt_req = 1'b1;
    at(176); evt_req = 1'b0;
    samp(179 + PLEN);
    chk("post_rst_start", 32'(pkt_start_cyc), 32'd177);
    chk("post_rst_ack_lat", 32'(evt_ack_cyc - pkt_start_cyc), 32'(PLEN));
`ifdef SFIFO_ARB_CSUM_EN
    chk("csum_last", last_wr_data, 32'h4000_0000);
`else
    chk("last_payload", last_wr_data, 32'h1);
`endif

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    samp(cyc + 2);
    chk("final_words", 32'(exp_q.size()), 32'd0);
    chk("final_acks", 32'(ack_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
